// File: rtl/dfi_chan_mux_pkg.sv
// Shared definitions for the DFI channel multiplexer.
//   - {cmd1,cmd0} encodings for read and write commands
//   - default interface widths and buffer depths
//   - chan_id_w(): width of a channel id, never less than one bit
package dfi_chan_mux_pkg;

  localparam logic [1:0] DfiRdEnc = 2'b01;
  localparam logic [1:0] DfiWrEnc = 2'b10;

  localparam int unsigned DfiNumChanDef     = 2;
  localparam int unsigned DfiDataWDef       = 128;
  localparam int unsigned DfiBankWDef       = 3;
  localparam int unsigned DfiAddrWDef       = 13;
  localparam int unsigned DfiCmdFifoDepthDef = 4;
  localparam int unsigned DfiTagFifoDepthDef = 16;
  localparam int unsigned DfiInitCyclesDef  = 16;

  function automatic int unsigned chan_id_w(input int unsigned num_chan);
    return (num_chan <= 2) ? 1 : $clog2(num_chan);
  endfunction

endpackage

// File: rtl/dfi_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk_i, rst_ni      clock, asynchronous active-low reset (flushes pointers/count)
//   push_i, wdata_i    write request and data (ignored when full)
//   pop_i, rdata_o     read request; rdata_o shows the current head (ignored when empty)
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries
// Depth must be a power of two, at least 2, so the pointers wrap naturally.
module dfi_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [Width-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [Width-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_i & (cnt_q != CntW'(Depth));
    do_pop  = pop_i & (cnt_q != '0);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/dfi_chan_mux.sv
// Time-multiplexes NUM_CHAN memory-controller channels onto one DRAM PHY interface.
//   clk, reset_poweron_n       single clock, asynchronous active-low reset
//   dfi__mmc__init_done        high INIT_CYCLES+1 cycles after reset release
//   mmc__dfi__* / dfi__mmc__ready   per-channel command valid/ready, cmd, bank, addr, wdata
//   dfi__phy__*                registered PHY command strobe, cmd, bank, addr, wdata
//   phy__dfi__valid/data       PHY read return
//   dfi__mmc__valid/data       per-channel read return (one-cycle valid pulse, data held)
//   dfi__mmc__rd_err           sticky: a read returned with no outstanding tag
// Each channel buffers commands in a FIFO; a round-robin arbiter pops one head per cycle.
// Issued reads push their channel id onto an in-order tag queue that steers returns.
module dfi_chan_mux
  import dfi_chan_mux_pkg::*;
#(
  parameter int unsigned NUM_CHAN       = DfiNumChanDef,
  parameter int unsigned DATA_W         = DfiDataWDef,
  parameter int unsigned BANK_W         = DfiBankWDef,
  parameter int unsigned ADDR_W         = DfiAddrWDef,
  parameter int unsigned CMD_FIFO_DEPTH = DfiCmdFifoDepthDef,
  parameter int unsigned TAG_FIFO_DEPTH = DfiTagFifoDepthDef,
  parameter int unsigned INIT_CYCLES    = DfiInitCyclesDef,
  parameter logic [1:0]  RD_ENC         = DfiRdEnc
) (
  input  logic                       clk,
  input  logic                       reset_poweron_n,
  output logic                       dfi__mmc__init_done,
  input  logic [NUM_CHAN-1:0]        mmc__dfi__valid,
  output logic [NUM_CHAN-1:0]        dfi__mmc__ready,
  input  logic [2*NUM_CHAN-1:0]      mmc__dfi__cmd,
  input  logic [BANK_W*NUM_CHAN-1:0] mmc__dfi__bank,
  input  logic [ADDR_W*NUM_CHAN-1:0] mmc__dfi__addr,
  input  logic [DATA_W*NUM_CHAN-1:0] mmc__dfi__data,
  output logic                       dfi__phy__cs,
  output logic                       dfi__phy__cmd1,
  output logic                       dfi__phy__cmd0,
  output logic [BANK_W-1:0]          dfi__phy__bank,
  output logic [ADDR_W-1:0]          dfi__phy__addr,
  output logic [DATA_W-1:0]          dfi__phy__data,
  input  logic                       phy__dfi__valid,
  input  logic [DATA_W-1:0]          phy__dfi__data,
  output logic [NUM_CHAN-1:0]        dfi__mmc__valid,
  output logic [DATA_W*NUM_CHAN-1:0] dfi__mmc__data,
  output logic                       dfi__mmc__rd_err
);

  localparam int unsigned ChanIdW  = chan_id_w(NUM_CHAN);
  localparam int unsigned CmdW     = 2 + BANK_W + ADDR_W + DATA_W;
  localparam int unsigned InitCntW = $clog2(INIT_CYCLES + 1);

  // Init counter
  logic [InitCntW-1:0] init_cnt_q, init_cnt_d;
  logic                init_done_q, init_done_d;

  always_comb begin
    init_cnt_d = init_cnt_q;
    if (init_cnt_q != InitCntW'(INIT_CYCLES)) begin
      init_cnt_d = init_cnt_q + 1'b1;
    end
    init_done_d = init_done_q | (init_cnt_q == InitCntW'(INIT_CYCLES));
  end

  // Per-channel command FIFOs
  logic [NUM_CHAN-1:0]                  cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CmdW-1:0]                      cmd_wdata [NUM_CHAN];
  logic [CmdW-1:0]                      cmd_head  [NUM_CHAN];
  logic [$clog2(CMD_FIFO_DEPTH+1)-1:0]  cmd_cnt_unused [NUM_CHAN];

  // Ready depends only on registered state, never on valid.
  assign dfi__mmc__ready = {NUM_CHAN{init_done_q}} & ~cmd_full;
  assign cmd_push        = mmc__dfi__valid & dfi__mmc__ready;

  for (genvar i = 0; i < int'(NUM_CHAN); i++) begin : g_cmd_fifo
    assign cmd_wdata[i] = {mmc__dfi__cmd[2*i +: 2],
                           mmc__dfi__bank[BANK_W*i +: BANK_W],
                           mmc__dfi__addr[ADDR_W*i +: ADDR_W],
                           mmc__dfi__data[DATA_W*i +: DATA_W]};

    dfi_sync_fifo #(
      .Width (CmdW),
      .Depth (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_poweron_n),
      .push_i  (cmd_push[i]),
      .wdata_i (cmd_wdata[i]),
      .pop_i   (cmd_pop[i]),
      .rdata_o (cmd_head[i]),
      .full_o  (cmd_full[i]),
      .empty_o (cmd_empty[i]),
      .count_o (cmd_cnt_unused[i])
    );
  end

  // Tag queue
  logic                                 tag_push, tag_pop, tag_full, tag_empty;
  logic [ChanIdW-1:0]                   tag_head;
  logic [$clog2(TAG_FIFO_DEPTH+1)-1:0]  tag_cnt_unused;

  // Arbitration
  logic [NUM_CHAN-1:0] issuable;
  logic [ChanIdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ChanIdW-1:0]  scan_idx;
  logic [ChanIdW-1:0]  win_idx;
  logic                win_valid;
  logic [CmdW-1:0]     win_entry;
  logic [1:0]          win_cmd;

  // A read head waits while the tag queue is full; a same-cycle tag pop is not counted.
  always_comb begin
    issuable = '0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      issuable[i] = ~cmd_empty[i] & ((cmd_head[i][CmdW-1 -: 2] != RD_ENC) | ~tag_full);
    end
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
      scan_idx = ChanIdW'((32'(rr_ptr_q) + k) % NUM_CHAN);
      if (!win_valid && issuable[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    cmd_pop   = '0;
    win_entry = cmd_head[win_idx];
    win_cmd   = win_entry[CmdW-1 -: 2];
    rr_ptr_d  = rr_ptr_q;
    if (win_valid) begin
      cmd_pop[win_idx] = 1'b1;
      rr_ptr_d = (win_idx == ChanIdW'(NUM_CHAN - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign tag_push = win_valid & (win_cmd == RD_ENC);
  assign tag_pop  = phy__dfi__valid & ~tag_empty;

  dfi_sync_fifo #(
    .Width (ChanIdW),
    .Depth (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_poweron_n),
    .push_i  (tag_push),
    .wdata_i (win_idx),
    .pop_i   (tag_pop),
    .rdata_o (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt_unused)
  );

  // PHY issue stage
  logic              phy_cs_q, phy_cs_d;
  logic [1:0]        phy_cmd_q, phy_cmd_d;
  logic [BANK_W-1:0] phy_bank_q, phy_bank_d;
  logic [ADDR_W-1:0] phy_addr_q, phy_addr_d;
  logic [DATA_W-1:0] phy_data_q, phy_data_d;

  always_comb begin
    phy_cs_d   = 1'b0;
    phy_cmd_d  = '0;
    phy_bank_d = '0;
    phy_addr_d = '0;
    phy_data_d = '0;
    if (win_valid) begin
      phy_cs_d   = 1'b1;
      phy_cmd_d  = win_cmd;
      phy_bank_d = win_entry[DATA_W+ADDR_W +: BANK_W];
      phy_addr_d = win_entry[DATA_W +: ADDR_W];
      phy_data_d = win_entry[DATA_W-1:0];
    end
  end

  // Read return routing
  logic [NUM_CHAN-1:0]        rd_valid_q, rd_valid_d;
  logic [DATA_W*NUM_CHAN-1:0] rd_data_q, rd_data_d;
  logic                       rd_err_q, rd_err_d;

  always_comb begin
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    if (phy__dfi__valid) begin
      if (tag_empty) begin
        rd_err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
          if (tag_head == ChanIdW'(i)) begin
            rd_valid_d[i] = 1'b1;
            rd_data_d[DATA_W*i +: DATA_W] = phy__dfi__data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rr_ptr_q    <= '0;
      phy_cs_q    <= 1'b0;
      phy_cmd_q   <= '0;
      phy_bank_q  <= '0;
      phy_addr_q  <= '0;
      phy_data_q  <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rr_ptr_q    <= rr_ptr_d;
      phy_cs_q    <= phy_cs_d;
      phy_cmd_q   <= phy_cmd_d;
      phy_bank_q  <= phy_bank_d;
      phy_addr_q  <= phy_addr_d;
      phy_data_q  <= phy_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign dfi__mmc__init_done = init_done_q;
  assign dfi__phy__cs        = phy_cs_q;
  assign dfi__phy__cmd1      = phy_cmd_q[1];
  assign dfi__phy__cmd0      = phy_cmd_q[0];
  assign dfi__phy__bank      = phy_bank_q;
  assign dfi__phy__addr      = phy_addr_q;
  assign dfi__phy__data      = phy_data_q;
  assign dfi__mmc__valid     = rd_valid_q;
  assign dfi__mmc__data      = rd_data_q;
  assign dfi__mmc__rd_err    = rd_err_q;

endmodule

// File: tb/tb_dfi_chan_mux.sv
// Self-checking bench for dfi_chan_mux with default parameters (2 channels, 16 tags).
module tb_dfi_chan_mux;
  import dfi_chan_mux_pkg::*;

  localparam int unsigned NC = 2;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 3;
  localparam int unsigned AW = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_done;
  logic [NC-1:0]     mmc_valid, ready, ret_valid;
  logic [2*NC-1:0]   mmc_cmd;
  logic [BW*NC-1:0]  mmc_bank;
  logic [AW*NC-1:0]  mmc_addr;
  logic [DW*NC-1:0]  mmc_data, ret_data;
  logic              cs, cmd1, cmd0;
  logic [BW-1:0]     phy_bank;
  logic [AW-1:0]     phy_addr;
  logic [DW-1:0]     phy_wdata;
  logic              phy_valid;
  logic [DW-1:0]     phy_rdata;
  logic              rd_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dfi_chan_mux u_dut (
    .clk                 (clk),
    .reset_poweron_n     (rst_n),
    .dfi__mmc__init_done (init_done),
    .mmc__dfi__valid     (mmc_valid),
    .dfi__mmc__ready     (ready),
    .mmc__dfi__cmd       (mmc_cmd),
    .mmc__dfi__bank      (mmc_bank),
    .mmc__dfi__addr      (mmc_addr),
    .mmc__dfi__data      (mmc_data),
    .dfi__phy__cs        (cs),
    .dfi__phy__cmd1      (cmd1),
    .dfi__phy__cmd0      (cmd0),
    .dfi__phy__bank      (phy_bank),
    .dfi__phy__addr      (phy_addr),
    .dfi__phy__data      (phy_wdata),
    .phy__dfi__valid     (phy_valid),
    .phy__dfi__data      (phy_rdata),
    .dfi__mmc__valid     (ret_valid),
    .dfi__mmc__data      (ret_data),
    .dfi__mmc__rd_err    (rd_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mmc_valid = '0;
    mmc_cmd   = '0;
    mmc_bank  = '0;
    mmc_addr  = '0;
    mmc_data  = '0;
    phy_valid = 1'b0;
    phy_rdata = '0;
  endtask

  task automatic drive_ch(input int ch, input logic [1:0] cmd, input logic [BW-1:0] bank,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mmc_valid[ch]         = 1'b1;
    mmc_cmd[2*ch +: 2]    = cmd;
    mmc_bank[BW*ch +: BW] = bank;
    mmc_addr[AW*ch +: AW] = addr;
    mmc_data[DW*ch +: DW] = data;
  endtask

  task automatic test_reset();
    int rise_at;
    bit early_bad;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({init_done, ready, cs, rd_err, ret_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {init_done, ready, cs, rd_err, ret_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rise_at   = 0;
    early_bad = 1'b0;
    for (int c = 1; c <= 30 && rise_at == 0; c++) begin
      step();
      if (init_done === 1'b1) rise_at = c;
      else if (ready !== '0 || cs !== 1'b0) early_bad = 1'b1;
    end
    total++;
    if (rise_at != 17) begin
      bad++;
      $display("FAIL init_done_latency: got %0d want 17", rise_at);
    end
    total++;
    if (early_bad) begin
      bad++;
      $display("FAIL ready_cs_before_init: got activity want none");
    end
    total++;
    if (ready !== 2'b11) begin
      bad++;
      $display("FAIL ready_after_init: got %b want 11", ready);
    end
  endtask

  task automatic test_rr_write();
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    int seqn [2];
    int ncs, accepted, ch;
    seqn[0] = 0;
    seqn[1] = 0;
    ncs = 0;
    accepted = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 1) begin
        total++;
        if (cs !== 1'b0) begin
          bad++;
          $display("FAIL rr_early_cs: got %b want 0", cs);
        end
      end
      if (c >= 2 && c < 10) begin
        total++;
        if (cs !== 1'b1) begin
          bad++;
          $display("FAIL rr_cs_stream: cycle %0d got %b want 1", c, cs);
        end
      end
      if (cs === 1'b1) begin
        ch = (phy_addr == 13'h020) ? 1 : 0;
        if (ncs < 8) begin
          total++;
          if (ch != ncs % 2) begin
            bad++;
            $display("FAIL rr_order: issue %0d got ch%0d want ch%0d", ncs, ch, ncs % 2);
          end
        end
        exp_a = (ch == 1) ? 13'h020 : 13'h010;
        exp_d = 'x;
        if (ch == 0 && q0.size() > 0) exp_d = q0.pop_front();
        if (ch == 1 && q1.size() > 0) exp_d = q1.pop_front();
        total++;
        if ({cmd1, cmd0, phy_bank, phy_addr, phy_wdata} !== {DfiWrEnc, 3'd0, exp_a, exp_d}) begin
          bad++;
          $display("FAIL rr_cmd: got cmd=%b%b addr=%h data=%h want cmd=%b addr=%h data=%h",
                   cmd1, cmd0, phy_addr, phy_wdata, DfiWrEnc, exp_a, exp_d);
        end
        ncs++;
      end
      if (c < 12) begin
        for (int i = 0; i < 2; i++) begin
          exp_d = {96'(i), 32'(seqn[i])};
          drive_ch(i, DfiWrEnc, 3'd0, (i == 0) ? 13'h010 : 13'h020, exp_d);
          if (ready[i] === 1'b1) begin
            if (i == 0) q0.push_back(exp_d);
            else q1.push_back(exp_d);
            seqn[i]++;
            accepted++;
          end
        end
      end else begin
        clear_inputs();
      end
      step();
    end
    total++;
    if (ncs != accepted || q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL rr_drain: got issued=%0d want %0d (left %0d/%0d)",
               ncs, accepted, q0.size(), q1.size());
    end
  endtask

  task automatic test_read_return();
    logic [2+BW+AW:0] exp_q[$];   // {ch, cmd, bank, addr}
    logic [2+BW+AW:0] e;
    int rd_chq[$];
    int ch;
    logic [DW-1:0] d1, d0;
    d1 = {4{32'hD1D1_0001}};
    d0 = {4{32'hD0D0_0000}};
    clear_inputs();
    total++;
    if (ready !== 2'b11) begin
      bad++;
      $display("FAIL rd_ready: got %b want 11", ready);
    end
    drive_ch(1, DfiRdEnc, 3'd2, 13'h1A0, '0);
    exp_q.push_back({1'b1, DfiRdEnc, 3'd2, 13'h1A0});
    step();
    clear_inputs();
    drive_ch(0, DfiRdEnc, 3'd0, 13'h050, '0);
    exp_q.push_back({1'b0, DfiRdEnc, 3'd0, 13'h050});
    step();
    clear_inputs();
    for (int c = 0; c < 8; c++) begin
      if (cs === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        rd_chq.push_back(int'(e[2+BW+AW]));
        total++;
        if ({cmd1, cmd0, phy_bank, phy_addr} !== e[1+BW+AW:0]) begin
          bad++;
          $display("FAIL rd_issue: got cmd=%b%b bank=%0d addr=%h want %h",
                   cmd1, cmd0, phy_bank, phy_addr, e[1+BW+AW:0]);
        end
      end
      step();
    end
    total++;
    if (exp_q.size() != 0 || rd_chq.size() != 2) begin
      bad++;
      $display("FAIL rd_issue_count: got %0d issued want 2", rd_chq.size());
    end
    ch = (rd_chq.size() > 0) ? rd_chq.pop_front() : 0;
    phy_valid = 1'b1;
    phy_rdata = d1;
    step();
    total++;
    if (ret_valid !== 2'(1 << ch) || ret_data[DW*ch +: DW] !== d1) begin
      bad++;
      $display("FAIL rd_return_first: got valid=%b data=%h want valid=%b data=%h",
               ret_valid, ret_data[DW*ch +: DW], 2'(1 << ch), d1);
    end
    ch = (rd_chq.size() > 0) ? rd_chq.pop_front() : 1;
    phy_rdata = d0;
    step();
    total++;
    if (ret_valid !== 2'(1 << ch) || ret_data[DW*ch +: DW] !== d0 || ret_data[DW +: DW] !== d1)
    begin
      bad++;
      $display("FAIL rd_return_second: got valid=%b data=%h want valid=%b data=%h",
               ret_valid, ret_data, 2'(1 << ch), d0);
    end
    phy_valid = 1'b0;
    step();
    total++;
    if (ret_valid !== 2'b00) begin
      bad++;
      $display("FAIL rd_return_pulse: got %b want 00", ret_valid);
    end
  endtask

  task automatic test_tag_full();
    int acc, n_rd, n_wr1, n_ret, n_drv;
    bit wrong;
    acc = 0; n_rd = 0; n_wr1 = 0; n_ret = 0; n_drv = 0; wrong = 1'b0;
    clear_inputs();
    for (int c = 0; c < 40; c++) begin
      if (cs === 1'b1) begin
        if ({cmd1, cmd0} === DfiRdEnc) n_rd++;
        else wrong = 1'b1;
      end
      if (acc < 18) begin
        drive_ch(0, DfiRdEnc, 3'd1, 13'(13'h100 + acc), '0);
        if (ready[0] === 1'b1) acc++;
      end else begin
        mmc_valid[0] = 1'b0;
      end
      step();
    end
    total++;
    if (n_rd != 16 || acc != 18 || wrong) begin
      bad++;
      $display("FAIL tag_full_stall: got issued=%0d accepted=%0d want 16/18", n_rd, acc);
    end
    drive_ch(1, DfiWrEnc, 3'd5, 13'h300, 128'hABCD);
    total++;
    if (ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL tag_full_wr_ready: got %b want 1", ready[1]);
    end
    step();
    mmc_valid[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (cs === 1'b1) begin
        if ({cmd1, cmd0} === DfiWrEnc && phy_addr === 13'h300) n_wr1++;
        else n_rd++;
      end
      step();
    end
    total++;
    if (n_wr1 != 1 || n_rd != 16) begin
      bad++;
      $display("FAIL tag_full_bypass: got wr=%0d rd=%0d want 1/16", n_wr1, n_rd);
    end
    phy_valid = 1'b1;
    phy_rdata = 128'h5A;
    n_drv = 1;
    step();
    phy_valid = 1'b0;
    total++;
    if (ret_valid !== 2'b01 || ret_data[DW-1:0] !== 128'h5A || cs !== 1'b0) begin
      bad++;
      $display("FAIL tag_full_return: got valid=%b cs=%b want 01/0", ret_valid, cs);
    end
    n_ret = 1;
    for (int c = 0; c < 6; c++) begin
      if (cs === 1'b1) n_rd++;
      step();
    end
    total++;
    if (n_rd != 17) begin
      bad++;
      $display("FAIL tag_full_unblock_one: got %0d want 17", n_rd);
    end
    for (int c = 0; c < 50; c++) begin
      if (cs === 1'b1) n_rd++;
      if (ret_valid[0] === 1'b1) n_ret++;
      if (ret_valid[1] !== 1'b0) wrong = 1'b1;
      phy_valid = (n_rd > n_drv);
      phy_rdata = DW'(c);
      if (phy_valid) n_drv++;
      step();
    end
    phy_valid = 1'b0;
    total++;
    if (n_rd != 18 || n_ret != 18 || wrong) begin
      bad++;
      $display("FAIL tag_full_drain: got issued=%0d returned=%0d want 18/18", n_rd, n_ret);
    end
  endtask

  task automatic test_rd_err();
    total++;
    if (rd_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_err_idle: got %b want 0", rd_err);
    end
    phy_valid = 1'b1;
    phy_rdata = 128'hBAD;
    step();
    phy_valid = 1'b0;
    total++;
    if (ret_valid !== 2'b00 || rd_err !== 1'b1) begin
      bad++;
      $display("FAIL rd_err_set: got valid=%b err=%b want 00/1", ret_valid, rd_err);
    end
    repeat (5) step();
    total++;
    if (rd_err !== 1'b1) begin
      bad++;
      $display("FAIL rd_err_sticky: got %b want 1", rd_err);
    end
  endtask

  task automatic test_reset_midflight();
    int n_rd, waited;
    bit stale;
    n_rd = 0;
    clear_inputs();
    drive_ch(0, DfiRdEnc, 3'd0, 13'h400, '0);
    drive_ch(1, DfiRdEnc, 3'd0, 13'h410, '0);
    step();
    drive_ch(0, DfiRdEnc, 3'd0, 13'h420, '0);
    drive_ch(1, DfiWrEnc, 3'd0, 13'h430, '0);
    step();
    drive_ch(0, DfiWrEnc, 3'd0, 13'h440, '0);
    for (int c = 0; c < 6; c++) begin
      if (cs === 1'b1 && {cmd1, cmd0} === DfiRdEnc) n_rd++;
      step();
    end
    total++;
    if (n_rd != 3) begin
      bad++;
      $display("FAIL midflight_reads: got %0d want 3", n_rd);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({init_done, ready, cs, cmd1, cmd0, phy_bank, phy_addr, phy_wdata,
         ret_valid, ret_data, rd_err} !== '0) begin
      bad++;
      $display("FAIL midflight_reset_outputs: got cs=%b ready=%b err=%b done=%b want 0",
               cs, ready, rd_err, init_done);
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    waited = 0;
    while (init_done !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL midflight_reinit: got init_done=%b want 1", init_done);
    end
    stale = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (cs !== 1'b0) stale = 1'b1;
      step();
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL midflight_stale_cmd: got cs activity want none");
    end
    phy_valid = 1'b1;
    phy_rdata = 128'h77;
    step();
    phy_valid = 1'b0;
    total++;
    if (ret_valid !== 2'b00 || rd_err !== 1'b1) begin
      bad++;
      $display("FAIL midflight_stale_tag: got valid=%b err=%b want 00/1", ret_valid, rd_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_rr_write();
    test_read_return();
    test_tag_full();
    test_rd_err();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
